// File: rtl/itype_imem_loader_if.sv
// Handshake and memory-write bundle for itype_imem_loader.
// master: program source / controller side; slave: the loader itself.
interface itype_imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       in_imm;
    logic [4:0]        in_rs1;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, in_valid, in_imm, in_rs1, in_funct3, in_rd, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow
    );

    modport slave (
        input  start, in_valid, in_imm, in_rs1, in_funct3, in_rd, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow
    );
endinterface

// File: rtl/itype_imem_loader.sv
// Packs streamed I-type ALU fields into RISC-V words (opcode 0010011) and
// writes them sequentially into the instruction memory write port.
// Optional macro ITYPE_LOADER_NOP_PAD_EN: after the last bundle, fill the
// remaining addresses with NOP (0x00000013) before signalling done.
module itype_imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    itype_imem_loader_if.slave      bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
`ifdef ITYPE_LOADER_NOP_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd3;
`endif

    localparam logic [6:0]        OPC_OPIMM = 7'b0010011;
    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PTR_MAX   = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              in_ready;
    logic              handshake;

    assign in_ready  = (state_q == ST_LOAD);
    assign handshake = bus.in_valid & in_ready;

    // Next-state, write-port and status logic for the load session.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    we_d     = 1'b1;
                    addr_d   = wr_ptr_q;
                    wdata_d  = {bus.in_imm, bus.in_rs1, bus.in_funct3, bus.in_rd, OPC_OPIMM};
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PTR_MAX) begin
                        // Last slot written: finish, flagging overflow if the program continues.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (!bus.in_last) begin
                            ovf_d = 1'b1;
                        end
                    end else if (bus.in_last) begin
`ifdef ITYPE_LOADER_NOP_PAD_EN
                        state_d = ST_PAD;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef ITYPE_LOADER_NOP_PAD_EN
            ST_PAD: begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = NOP_WORD;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == PTR_MAX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered write port; synchronous reset returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
`ifdef ITYPE_LOADER_NOP_PAD_EN
    assign bus.busy       = (state_q == ST_LOAD) | (state_q == ST_PAD);
`else
    assign bus.busy       = (state_q == ST_LOAD);
`endif
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
endmodule
